syscall_ctrl: RTL and testbench

SYSCALL_CTRL -- requirements
Module: syscall_ctrl

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/syscall_ctrl.sv | 170 +++++++++++++++++
 tb/tb_syscall_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the CPU control blocks.
//   state_e      : syscall controller FSM states
//   stop_kind_e  : what a pending stop turns into once the delay expires
//   svc_kind_e   : decoded class of a syscall service code
//   SVC_*_DEFAULT: default service codes (v0 values) recognised by syscall_ctrl
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DELAY  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic {
    STOP_PAUSE = 1'b0,
    STOP_HALT  = 1'b1
  } stop_kind_e;

  typedef enum logic [1:0] {
    SVC_K_PRINT = 2'd0,
    SVC_K_PAUSE = 2'd1,
    SVC_K_HALT  = 2'd2,
    SVC_K_OTHER = 2'd3
  } svc_kind_e;

  localparam logic [31:0] SVC_PRINT_DEFAULT = 32'h0000_0001;
  localparam logic [31:0] SVC_PAUSE_DEFAULT = 32'h0000_0032;
  localparam logic [31:0] SVC_HALT_DEFAULT  = 32'h0000_000a;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read port.
//   clock, reset : clock and synchronous active-high reset
//   push_i       : write wdata_i (honoured when not full, or when full and an
//                  effective pop happens in the same cycle)
//   pop_i        : drop the head entry (ignored when empty)
//   wdata_i      : write data
//   rdata_o      : head entry, 0 when empty
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : occupancy, 0..DEPTH
// DEPTH must be a power of two (pointers wrap by natural overflow), >= 2.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO may accept a
  // push when it is also being popped.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; rdata_o is masked to 0 while
  // empty, so stale contents are never visible and the array maps to plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/syscall_ctrl.sv
// -----------------------------------------------------------------------------
// syscall_ctrl
// Services CPU syscall instructions: print (queue reg_t for a display),
// pause (stop until resume) and halt (stop until reset).
//   clock, reset : clock and synchronous active-high reset
//   syscall      : syscall in decode/execute this cycle
//   reg_s        : service code (v0)
//   reg_t        : argument (a0)
//   resume       : one-cycle pulse releasing a pause
//   out_pop      : display consumer pops the print FIFO head
//   enable       : CPU clock enable (low stalls the pipeline)
//   out_data     : print FIFO head, 0 when empty
//   out_valid    : print FIFO not empty
//   out_count    : print FIFO occupancy
//   paused       : controller is in PAUSED
//   halted       : controller is in HALTED
//   bad_svc      : sticky flag, an unknown service code was seen
// A pause/halt stops the CPU HALT_DELAY cycles after the syscall edge so
// in-flight instructions can drain. A print to a full FIFO stalls the CPU
// combinationally; the held syscall retries until a slot frees up.
// -----------------------------------------------------------------------------
module syscall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       HALT_DELAY = 2,
  parameter logic [DATA_W-1:0] SVC_PRINT  = DATA_W'(SVC_PRINT_DEFAULT),
  parameter logic [DATA_W-1:0] SVC_PAUSE  = DATA_W'(SVC_PAUSE_DEFAULT),
  parameter logic [DATA_W-1:0] SVC_HALT   = DATA_W'(SVC_HALT_DEFAULT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        syscall,
  input  logic [DATA_W-1:0]           reg_s,
  input  logic [DATA_W-1:0]           reg_t,
  input  logic                        resume,
  input  logic                        out_pop,
  output logic                        enable,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  output logic [$clog2(FIFO_DEPTH):0] out_count,
  output logic                        paused,
  output logic                        halted,
  output logic                        bad_svc
);

  localparam int unsigned CNT_W = $clog2(HALT_DELAY + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  stop_kind_e         kind_q,  kind_d;
  logic               bad_q,   bad_d;

  svc_kind_e          svc;
  logic               print_req;
  logic               stall;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;

  // ---------------------------------------------------------------------------
  // Service-code decode
  // ---------------------------------------------------------------------------
  always_comb begin
    if (reg_s == SVC_PRINT)      svc = SVC_K_PRINT;
    else if (reg_s == SVC_PAUSE) svc = SVC_K_PAUSE;
    else if (reg_s == SVC_HALT)  svc = SVC_K_HALT;
    else                         svc = SVC_K_OTHER;
  end

  // Prints are only serviced while running. A full FIFO accepts the push only
  // when the consumer pops in the same cycle; otherwise the CPU is held so the
  // same syscall is presented again next cycle and nothing is lost.
  assign print_req = syscall && (state_q == ST_RUN) && (svc == SVC_K_PRINT);
  assign stall     = print_req && fifo_full && !out_pop;
  assign fifo_push = print_req && !stall;

  // ---------------------------------------------------------------------------
  // Print FIFO (poppable in every state)
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_print_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (out_pop),
    .wdata_i (reg_t),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (out_count)
  );

  assign out_valid = !fifo_empty;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and enable
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    bad_d   = bad_q;
    enable  = 1'b0;

    case (state_q)
      ST_RUN: begin
        enable = !stall;
        if (syscall) begin
          case (svc)
            SVC_K_PAUSE: begin
              state_d = ST_DELAY;
              cnt_d   = CNT_W'(HALT_DELAY);
              kind_d  = STOP_PAUSE;
            end
            SVC_K_HALT: begin
              state_d = ST_DELAY;
              cnt_d   = CNT_W'(HALT_DELAY);
              kind_d  = STOP_HALT;
            end
            SVC_K_OTHER: bad_d = 1'b1;
            default: ;  // print handled by the FIFO path
          endcase
        end
      end

      ST_DELAY: begin
        // Counter reaches 0 on the exit edge, leaving it idle while stopped.
        enable = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = (kind_q == STOP_HALT) ? ST_HALTED : ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        if (resume) state_d = ST_RUN;
      end

      ST_HALTED: ;  // only reset leaves HALTED

      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      kind_q  <= STOP_PAUSE;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      bad_q   <= bad_d;
    end
  end

  assign paused  = (state_q == ST_PAUSED);
  assign halted  = (state_q == ST_HALTED);
  assign bad_svc = bad_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_syscall_ctrl
// Directed scenarios for pause, halt, print back-pressure, bad service codes
// and reset priority, followed by a randomized run against a queue-based
// behavioural model. Default parameters: DATA_W 32, FIFO_DEPTH 4, HALT_DELAY 2.
// -----------------------------------------------------------------------------
module tb_syscall_ctrl;

  localparam logic [31:0] C_PRINT = 32'h1;
  localparam logic [31:0] C_PAUSE = 32'h32;
  localparam logic [31:0] C_HALT  = 32'ha;
  localparam int          DEPTH   = 4;
  localparam int          DELAY   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        syscall;
  logic [31:0] reg_s;
  logic [31:0] reg_t;
  logic        resume;
  logic        out_pop;
  logic        enable;
  logic [31:0] out_data;
  logic        out_valid;
  logic [2:0]  out_count;
  logic        paused;
  logic        halted;
  logic        bad_svc;

  int tests_run    = 0;
  int tests_failed = 0;

  // {enable, paused, halted, bad_svc, out_valid, out_count[2:0]}
  wire [7:0] flags = {enable, paused, halted, bad_svc, out_valid, out_count};

  syscall_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .syscall   (syscall),
    .reg_s     (reg_s),
    .reg_t     (reg_t),
    .resume    (resume),
    .out_pop   (out_pop),
    .enable    (enable),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_count (out_count),
    .paused    (paused),
    .halted    (halted),
    .bad_svc   (bad_svc)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
  // after that, well away from the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    syscall = 1'b0;
    resume  = 1'b0;
    out_pop = 1'b0;
    reg_s   = '0;
    reg_t   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want %b", flags, 8'b1000_0000);
    end
    tests_run++;
    if (out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data got %h want %h", out_data, 32'h0);
    end
  endtask

  task automatic test_halt();
    do_reset();
    syscall = 1'b1; reg_s = C_HALT; #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL halt_n got %b want %b", flags, 8'b1000_0000);
    end
    tick(); syscall = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL halt_n1 got %b want %b", flags, 8'b1000_0000);
    end
    tick(); #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL halt_n2 got %b want %b", flags, 8'b1000_0000);
    end
    tick(); #2;
    tests_run++;
    if (flags !== 8'b0010_0000) begin
      tests_failed++; $display("FAIL halt_n3 got %b want %b", flags, 8'b0010_0000);
    end
    resume = 1'b1; tick(); resume = 1'b0; tick();
    resume = 1'b1; tick(); resume = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b0010_0000) begin
      tests_failed++; $display("FAIL halt_resume got %b want %b", flags, 8'b0010_0000);
    end
    syscall = 1'b1; reg_s = C_PRINT; reg_t = 32'h99; tick(); syscall = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b0010_0000) begin
      tests_failed++; $display("FAIL halt_ignore_print got %b want %b", flags, 8'b0010_0000);
    end
    do_reset(); #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL halt_reset got %b want %b", flags, 8'b1000_0000);
    end
  endtask

  task automatic test_pause();
    do_reset();
    syscall = 1'b1; reg_s = C_PAUSE; tick(); syscall = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL pause_n1 got %b want %b", flags, 8'b1000_0000);
    end
    tick(); tick(); #2;
    tests_run++;
    if (flags !== 8'b0100_0000) begin
      tests_failed++; $display("FAIL pause_n3 got %b want %b", flags, 8'b0100_0000);
    end
    syscall = 1'b1; reg_s = C_HALT; tick(); syscall = 1'b0; tick(); tick();
    resume = 1'b1; #2;
    tests_run++;
    if (flags !== 8'b0100_0000) begin
      tests_failed++; $display("FAIL pause_n6 got %b want %b", flags, 8'b0100_0000);
    end
    tick(); resume = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL pause_n7 got %b want %b", flags, 8'b1000_0000);
    end
  endtask

  task automatic test_print_full();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      syscall = 1'b1; reg_s = C_PRINT; reg_t = 32'(i); #2;
      tests_run++;
      if (enable !== 1'b1) begin
        tests_failed++; $display("FAIL print_fill_en%0d got %b want %b", i, enable, 1'b1);
      end
      tick();
    end
    reg_t = 32'd5;
    for (int k = 0; k < 2; k++) begin
      #2;
      tests_run++;
      if (flags !== 8'b0000_1100 || out_data !== 32'd1) begin
        tests_failed++;
        $display("FAIL print_stall%0d got %b/%h want %b/%h", k, flags, out_data, 8'b0000_1100, 32'd1);
      end
      tick();
    end
    out_pop = 1'b1; #2;
    tests_run++;
    if (enable !== 1'b1) begin
      tests_failed++; $display("FAIL print_release_en got %b want %b", enable, 1'b1);
    end
    tick(); syscall = 1'b0; out_pop = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_1100) begin
      tests_failed++; $display("FAIL print_after_release got %b want %b", flags, 8'b1000_1100);
    end
    for (int v = 2; v <= 5; v++) begin
      tests_run++;
      if (out_data !== 32'(v)) begin
        tests_failed++; $display("FAIL print_drain got %h want %h", out_data, 32'(v));
      end
      out_pop = 1'b1; tick(); out_pop = 1'b0; #2;
    end
    tests_run++;
    if (flags !== 8'b1000_0000 || out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL print_empty got %b/%h want %b/%h", flags, out_data, 8'b1000_0000, 32'h0);
    end
    out_pop = 1'b1; tick(); out_pop = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL print_pop_empty got %b want %b", flags, 8'b1000_0000);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] vals [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      syscall = 1'b1; reg_s = C_PRINT; reg_t = vals[i]; tick();
    end
    reg_t = $urandom; out_pop = 1'b1; #2;
    tests_run++;
    if (enable !== 1'b1) begin
      tests_failed++; $display("FAIL fullpop_en got %b want %b", enable, 1'b1);
    end
    tick(); syscall = 1'b0; out_pop = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_1100 || out_data !== vals[1]) begin
      tests_failed++;
      $display("FAIL fullpop_state got %b/%h want %b/%h", flags, out_data, 8'b1000_1100, vals[1]);
    end
  endtask

  task automatic test_bad_svc();
    do_reset();
    syscall = 1'b1; reg_s = C_PRINT; reg_t = 32'h55; tick();
    reg_s = 32'h7; #2;
    tests_run++;
    if (enable !== 1'b1) begin
      tests_failed++; $display("FAIL bad_en got %b want %b", enable, 1'b1);
    end
    tick(); syscall = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1001_1001 || out_data !== 32'h55) begin
      tests_failed++;
      $display("FAIL bad_set got %b/%h want %b/%h", flags, out_data, 8'b1001_1001, 32'h55);
    end
    tick(); tick(); tick(); #2;
    tests_run++;
    if (bad_svc !== 1'b1) begin
      tests_failed++; $display("FAIL bad_sticky got %b want %b", bad_svc, 1'b1);
    end
    do_reset(); #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL bad_reset got %b want %b", flags, 8'b1000_0000);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    syscall = 1'b1; reg_s = C_HALT; tick(); syscall = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_0000) begin
      tests_failed++; $display("FAIL rstdelay_now got %b want %b", flags, 8'b1000_0000);
    end
    for (int i = 0; i < 6; i++) begin
      tick(); #2;
      tests_run++;
      if (flags !== 8'b1000_0000) begin
        tests_failed++; $display("FAIL rstdelay_later%0d got %b want %b", i, flags, 8'b1000_0000);
      end
    end
    for (int i = 0; i < 4; i++) begin
      syscall = 1'b1; reg_s = C_PRINT; reg_t = 32'(i + 10); tick();
    end
    reg_t = 32'd20; #2;
    tests_run++;
    if (enable !== 1'b0) begin
      tests_failed++; $display("FAIL rststall_en got %b want %b", enable, 1'b0);
    end
    reset = 1'b1; out_pop = 1'b1; tick();
    reset = 1'b0; out_pop = 1'b0; syscall = 1'b0; #2;
    tests_run++;
    if (flags !== 8'b1000_0000 || out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rststall_state got %b/%h want %b/%h", flags, out_data, 8'b1000_0000, 32'h0);
    end
  endtask

  // Randomized run against a behavioural model: a queue for the print
  // buffer plus a "running / stopping in k cycles / paused / halted" mode.
  task automatic test_random();
    logic [31:0] q[$];
    int          mode;      // 0 running, 1 stopping, 2 paused, 3 halted
    int          left;      // edges remaining before a pending stop lands
    bit          want_halt;
    bit          bad;
    bit          r_rst, is_print, stall;
    int          sel;
    logic [39:0] got, exp;
    logic [31:0] exp_data;

    do_reset();
    q.delete(); mode = 0; left = 0; want_halt = 0; bad = 0;
    for (int c = 0; c < 800; c++) begin
      r_rst   = ($urandom_range(39) == 0);
      syscall = ($urandom_range(2) == 0);
      sel     = $urandom_range(9);
      if (sel <= 5)      reg_s = C_PRINT;
      else if (sel == 6) reg_s = C_PAUSE;
      else if (sel == 7) reg_s = C_HALT;
      else               reg_s = 32'h100 + 32'($urandom_range(255));
      reg_t   = $urandom;
      resume  = ($urandom_range(3) == 0);
      out_pop = ($urandom_range(2) == 0);
      reset   = r_rst;
      #2;

      is_print = syscall && (mode == 0) && (reg_s == C_PRINT);
      stall    = is_print && (q.size() == DEPTH) && !out_pop;
      exp_data = (q.size() != 0) ? q[0] : 32'h0;
      exp = {((mode <= 1) && !stall), (mode == 2), (mode == 3), bad,
             (q.size() != 0), 3'(q.size()), exp_data};
      got = {flags, out_data};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random_c%0d got %h want %h", c, got, exp);
      end

      if (r_rst) begin
        q.delete(); mode = 0; left = 0; bad = 0;
      end else begin
        if (out_pop && q.size() != 0) void'(q.pop_front());
        if (is_print && !stall) q.push_back(reg_t);
        case (mode)
          0: if (syscall) begin
               if (reg_s == C_PAUSE || reg_s == C_HALT) begin
                 mode = 1; left = DELAY; want_halt = (reg_s == C_HALT);
               end else if (reg_s != C_PRINT) begin
                 bad = 1;
               end
             end
          1: begin
               left--;
               if (left == 0) mode = want_halt ? 3 : 2;
             end
          2: if (resume) mode = 0;
          default: ;
        endcase
      end
      tick();
    end
    reset = 1'b0; syscall = 1'b0; resume = 1'b0; out_pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; syscall = 1'b0; resume = 1'b0; out_pop = 1'b0;
    reg_s = '0; reg_t = '0;
    test_reset();
    test_halt();
    test_pause();
    test_print_full();
    test_full_pop();
    test_bad_svc();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
